parameterized_uart_rx: RTL and testbench
========================================

Name: parameterized_uart_rx

Overview:
- Parameterized UART receiver; the receive-side counterpart of the team's parameterized UART transmitter, with identical frame format parameters.
- Frame: one start bit (low), DATA_WIDTH data bits LSB-first, optional parity bit, then STOP_BITS stop bits (high).
- Synchronizes the asynchronous rx line and samples each bit at mid-bit.
- Delivers each received word with a one-cycle valid strobe plus parity and framing error flags.

Parameters:
- DATA_WIDTH, 8, data bits per frame (5-9).
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_TYPE, 0, 0 = even, 1 = odd; the parity bit equals ^data for even and ~^data for odd.
- STOP_BITS, 1, number of stop bits (1 or 2).
- CLOCK_FREQ, 50_000_000, clock frequency in Hz.
- BAUD_RATE, 115200, bits per second.
- Derived localparams: CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE, which must be at least 4. HALF_BIT = CLKS_PER_BIT/2.

Ports:
- clk  input  1  system clock; single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- rx  input  1  UART line; asynchronous to clk; idles high.
- data_out  output  DATA_WIDTH  last received word.
- data_valid  output  1  one-cycle strobe: data_out, parity_err and frame_err are updated.
- parity_err  output  1  parity mismatch on the last word; always 0 when PARITY_EN=0.
- frame_err  output  1  a stop bit sampled low on the last word.
- rx_busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset values: data_out=0, data_valid=0, parity_err=0, frame_err=0, rx_busy=0, state=IDLE. Both synchronizer flops reset to 1.
- Input path: a two-flop synchronizer produces rx_s. All decisions use rx_s, so there are 2 cycles of input latency.
- States: IDLE, START, DATA, PARITY, STOP. A bit_timer counts clk cycles and a bit_counter counts bits.
- IDLE:
  - bit_timer=0, bit_counter=0.
  - If rx_s==0, go to START.
- START:
  - When bit_timer reaches HALF_BIT-1, sample rx_s.
  - rx_s==1: false start (glitch). Return to IDLE; no strobe, no flag change.
  - rx_s==0: clear bit_timer and go to DATA.
- DATA:
  - Every CLKS_PER_BIT cycles (bit_timer == CLKS_PER_BIT-1), sample rx_s, shift it into the MSB of the shift register (LSB-first reception), then clear bit_timer.
  - After DATA_WIDTH samples, go to PARITY if PARITY_EN, otherwise STOP.
- PARITY:
  - Sample after CLKS_PER_BIT cycles.
  - Latch an internal parity-error bit = sampled bit XOR expected parity of the shift register.
- STOP:
  - Sample after CLKS_PER_BIT cycles; a low sample sets an internal frame-error bit.
  - With STOP_BITS=2, sample a second stop bit CLKS_PER_BIT cycles later; the frame error is the OR of both samples being low.
  - After the final stop sample, on the next edge:
    - data_valid=1 for exactly one cycle.
    - data_out takes the shift register.
    - parity_err and frame_err take the internal bits.
    - state returns to IDLE.
- Return to IDLE happens at mid-stop-bit, so a start bit immediately following the stop bit is caught with no lost frame.
- Output hold: data_out, parity_err and frame_err are updated only on the data_valid cycle and hold otherwise. Data is delivered even when parity or framing is bad.
- Break condition (rx held low): yields a frame with data=0 and frame_err=1. The block then stays in IDLE, but because rx_s is still low it immediately re-enters START. It therefore produces repeated framing-error words every frame time until rx returns high. No special break detection.
- There is no ready/backpressure: the consumer must take data within one frame time.
- Reset asserted mid-frame: all state clears immediately, with no strobe on release. The next falling edge of rx after reset release starts a new frame.
- Width rules:
  - bit_timer is $clog2(CLKS_PER_BIT) bits wide.
  - bit_counter is $clog2(DATA_WIDTH+1) bits wide.
  - A single stop-bit index flop is used.
  - All comparisons use localparam constants.

Decomposition:
- Shared package uart_pkg:
  - state encoding IDLE/START/DATA/PARITY/STOP (3 bits), shared with the transmitter;
  - parity-type constants PARITY_EVEN=0 and PARITY_ODD=1;
  - a clks-per-bit calculation function.
- One natural sub-module: uart_rx_sync, the two-flop synchronizer with reset value 1 (parameterized stages, default 2).
- FSM, timer and shift register stay in the top module.

Test Plan (CLOCK_FREQ=1_000_000, BAUD_RATE=100_000 → CLKS_PER_BIT=10):
1. Defaults, send 0xA5 with a correct frame → one data_valid pulse at about 9.5 bit times after the start edge plus 2 cycles; data_out=0xA5, parity_err=0, frame_err=0.
2. PARITY_EN=1, PARITY_TYPE=0:
   - send 0x07 with parity bit 1 → parity_err=0.
   - send 0x07 with parity bit 0 → parity_err=1, data_out=0x07.
3. Send 0x3C with the stop bit driven low → data_valid pulses, frame_err=1, data_out=0x3C; the next clean 0x55 frame gives frame_err=0.
4. Low glitch of 3 cycles on idle rx → no data_valid; rx_busy returns to 0 within HALF_BIT+3 cycles.
5. STOP_BITS=2, send back-to-back 0x01 and 0xFE → two strobes in order, no errors. A second stop bit driven low → frame_err=1.
6. Assert rst_n mid-DATA of a 0x81 frame → outputs at reset values and no strobe. A following 0x42 frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART definitions shared by the receiver and the transmitter
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int PARITY_EVEN = 0;
  localparam int PARITY_ODD  = 1;

  function automatic int clks_per_bit(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - multi-flop synchronizer for the asynchronous rx line
// Resets to 1 so an idle-high line never looks like a start bit out of reset.
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/parameterized_uart_rx.sv
// rtl/parameterized_uart_rx.sv - UART receiver with mid-bit sampling, parity and framing checks
module parameterized_uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_TYPE = 0,
  parameter int STOP_BITS   = 1,
  parameter int CLOCK_FREQ  = 50_000_000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  rx_busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TIMER_W      = $clog2(CLKS_PER_BIT);
  localparam int CNT_W        = $clog2(DATA_WIDTH + 1);

  localparam logic [TIMER_W-1:0] TIMER_HALF = TIMER_W'(HALF_BIT - 1);
  localparam logic [TIMER_W-1:0] TIMER_FULL = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DATA_WIDTH - 1);
  localparam logic               STOP_LAST  = (STOP_BITS == 2);

  uart_state_e           state_q, state_d;
  logic [TIMER_W-1:0]    bit_timer_q, bit_timer_d;
  logic [CNT_W-1:0]      bit_counter_q, bit_counter_d;
  logic                  stop_idx_q, stop_idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  par_bad_q, par_bad_d;
  logic                  frm_bad_q, frm_bad_d;
  logic                  data_valid_q, data_valid_d;
  logic                  parity_err_q, parity_err_d;
  logic                  frame_err_q, frame_err_d;
  logic                  rx_s;
  logic                  exp_parity;
  logic                  timer_full;
  logic                  frm_bad_now;

  uart_rx_sync #(.STAGES(2)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  always_comb begin
    exp_parity    = (PARITY_TYPE == PARITY_ODD) ? ~^shift_q : ^shift_q;
    timer_full    = (bit_timer_q == TIMER_FULL);
    frm_bad_now   = frm_bad_q | ~rx_s;
    state_d       = state_q;
    bit_timer_d   = bit_timer_q + 1'b1;
    bit_counter_d = bit_counter_q;
    stop_idx_d    = stop_idx_q;
    shift_d       = shift_q;
    par_bad_d     = par_bad_q;
    frm_bad_d     = frm_bad_q;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    parity_err_d  = parity_err_q;
    frame_err_d   = frame_err_q;
    unique case (state_q)
      IDLE: begin
        bit_timer_d   = '0;
        bit_counter_d = '0;
        stop_idx_d    = 1'b0;
        par_bad_d     = 1'b0;
        frm_bad_d     = 1'b0;
        if (!rx_s) state_d = START;
      end
      START: begin
        // A line that is high again at mid-start-bit was only a glitch.
        if (bit_timer_q == TIMER_HALF) begin
          bit_timer_d = '0;
          state_d     = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer_full) begin
          bit_timer_d   = '0;
          shift_d       = {rx_s, shift_q[DATA_WIDTH-1:1]};
          bit_counter_d = bit_counter_q + 1'b1;
          if (bit_counter_q == CNT_LAST) state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (timer_full) begin
          bit_timer_d = '0;
          par_bad_d   = rx_s ^ exp_parity;
          state_d     = STOP;
        end
      end
      STOP: begin
        // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
        if (timer_full) begin
          bit_timer_d = '0;
          frm_bad_d   = frm_bad_now;
          if (stop_idx_q == STOP_LAST) begin
            state_d      = IDLE;
            data_valid_d = 1'b1;
            data_out_d   = shift_q;
            parity_err_d = par_bad_q;
            frame_err_d  = frm_bad_now;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      bit_timer_q   <= '0;
      bit_counter_q <= '0;
      stop_idx_q    <= 1'b0;
      shift_q       <= '0;
      par_bad_q     <= 1'b0;
      frm_bad_q     <= 1'b0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      parity_err_q  <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_timer_q   <= bit_timer_d;
      bit_counter_q <= bit_counter_d;
      stop_idx_q    <= stop_idx_d;
      shift_q       <= shift_d;
      par_bad_q     <= par_bad_d;
      frm_bad_q     <= frm_bad_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      parity_err_q  <= parity_err_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign rx_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_parameterized_uart_rx.sv
// tb/tb_parameterized_uart_rx.sv - randomized and directed checks of parameterized_uart_rx
// Three receivers: 8N1, 8E1 and 8O2, each fed from its own serial line.
module tb_parameterized_uart_rx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int HALF   = CPB / 2;
  localparam int N      = 3;

  typedef struct {
    int         inst;
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         due;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_line [N];
  logic [7:0] do_w    [N];
  logic       dv_w    [N];
  logic       pe_w    [N];
  logic       fe_w    [N];
  logic       busy_w  [N];
  logic [9:0] held    [N];
  int         cyc   = 0;
  int         total = 0;
  int         bad   = 0;
  exp_t       exp_q[$];

  int p_en   [N] = '{0, 1, 1};
  int p_odd  [N] = '{0, 0, 1};
  int s_bits [N] = '{1, 1, 2};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  parameterized_uart_rx #(.DATA_WIDTH(8), .PARITY_EN(0), .PARITY_TYPE(0), .STOP_BITS(1),
                          .CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD)) u_rx0 (
    .clk(clk), .rst_n(rst_n), .rx(rx_line[0]), .data_out(do_w[0]), .data_valid(dv_w[0]),
    .parity_err(pe_w[0]), .frame_err(fe_w[0]), .rx_busy(busy_w[0]));

  parameterized_uart_rx #(.DATA_WIDTH(8), .PARITY_EN(1), .PARITY_TYPE(0), .STOP_BITS(1),
                          .CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD)) u_rx1 (
    .clk(clk), .rst_n(rst_n), .rx(rx_line[1]), .data_out(do_w[1]), .data_valid(dv_w[1]),
    .parity_err(pe_w[1]), .frame_err(fe_w[1]), .rx_busy(busy_w[1]));

  parameterized_uart_rx #(.DATA_WIDTH(8), .PARITY_EN(1), .PARITY_TYPE(1), .STOP_BITS(2),
                          .CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD)) u_rx2 (
    .clk(clk), .rst_n(rst_n), .rx(rx_line[2]), .data_out(do_w[2]), .data_valid(dv_w[2]),
    .parity_err(pe_w[2]), .frame_err(fe_w[2]), .rx_busy(busy_w[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp_v);
    end
  endtask

  // Correct parity bit by counting ones: even -> total ones even, odd -> total ones odd.
  function automatic logic model_par(input logic [7:0] d, input int odd);
    int ones = 0;
    for (int b = 0; b < 8; b++) ones += int'(d[b]);
    return (odd != 0) ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  task automatic send_frame(input int i, input logic [7:0] d, input logic pbit,
                            input logic s0, input logic s1, input int gap);
    exp_t e;
    logic lv[$];
    lv.push_back(1'b0);
    for (int b = 0; b < 8; b++) lv.push_back(d[b]);
    if (p_en[i] != 0) lv.push_back(pbit);
    lv.push_back(s0);
    if (s_bits[i] == 2) lv.push_back(s1);
    e.inst = i;
    e.d    = d;
    e.pe   = (p_en[i] != 0) && (pbit != model_par(d, p_odd[i]));
    e.fe   = !s0 || (s_bits[i] == 2 && !s1);
    // Middle of the last stop bit, plus two synchronizer cycles and the output register.
    e.due  = cyc + HALF + CPB * (lv.size() - 1) + 3;
    exp_q.push_back(e);
    foreach (lv[k]) begin
      rx_line[i] = lv[k];
      repeat (CPB) @(negedge clk);
    end
    rx_line[i] = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        chk("reset_state", 32'({dv_w[i], do_w[i], pe_w[i], fe_w[i], busy_w[i]}), 32'd0);
        held[i] = '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (dv_w[i]) begin
          total++;
          if (exp_q.size() == 0 || exp_q[0].inst != i) begin
            bad++;
            $display("FAIL spurious_strobe: inst %0d got data %h want no strobe", i, do_w[i]);
          end else begin
            e = exp_q.pop_front();
            chk("strobe_word", 32'({do_w[i], pe_w[i], fe_w[i]}), 32'({e.d, e.pe, e.fe}));
            total++;
            if (cyc < e.due - 2 || cyc > e.due + 2) begin
              bad++;
              $display("FAIL strobe_time: inst %0d got cycle %0d want %0d +-2", i, cyc, e.due);
            end
            held[i] = {e.d, e.pe, e.fe};
          end
        end else begin
          chk("hold_outputs", 32'({do_w[i], pe_w[i], fe_w[i]}), 32'(held[i]));
        end
      end
      if (exp_q.size() > 0 && cyc > exp_q[0].due + 2) begin
        total++;
        bad++;
        $display("FAIL strobe_timeout: inst %0d got no strobe want one by cycle %0d",
                 exp_q[0].inst, exp_q[0].due + 2);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int         ri;
    logic [7:0] rd;
    logic       rp, rs0, rs1, clean, saw;
    for (int i = 0; i < N; i++) rx_line[i] = 1'b1;

    chk("pin_par_even_07", 32'(model_par(8'h07, 0)), 32'd1);
    chk("pin_par_odd_07", 32'(model_par(8'h07, 1)), 32'd0);
    chk("pin_par_odd_fe", 32'(model_par(8'hFE, 1)), 32'd0);

    repeat (4) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);

    send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1, CPB);
    chk("t1_data", 32'(do_w[0]), 32'h0000_00A5);
    chk("t1_flags", 32'({pe_w[0], fe_w[0]}), 32'd0);

    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, CPB);
    chk("t2_good_parity", 32'(pe_w[1]), 32'd0);
    send_frame(1, 8'h07, 1'b0, 1'b1, 1'b1, CPB);
    chk("t2_bad_parity", 32'(pe_w[1]), 32'd1);
    chk("t2_bad_parity_data", 32'(do_w[1]), 32'h0000_0007);

    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, CPB);
    chk("t3_frame_err", 32'({do_w[0], fe_w[0]}), 32'({8'h3C, 1'b1}));
    send_frame(0, 8'h55, 1'b0, 1'b1, 1'b1, CPB);
    chk("t3_recover", 32'({do_w[0], fe_w[0]}), 32'({8'h55, 1'b0}));

    rx_line[0] = 1'b0;
    saw = 1'b0;
    for (int k = 1; k <= HALF + 3; k++) begin
      @(negedge clk);
      if (k == 3) rx_line[0] = 1'b1;
      if (busy_w[0]) saw = 1'b1;
    end
    chk("t4_glitch_busy_seen", 32'(saw), 32'd1);
    chk("t4_glitch_idle", 32'(busy_w[0]), 32'd0);
    repeat (2 * CPB) @(negedge clk);

    send_frame(2, 8'h01, model_par(8'h01, 1), 1'b1, 1'b1, 0);
    send_frame(2, 8'hFE, model_par(8'hFE, 1), 1'b1, 1'b1, CPB);
    chk("t5_second_word", 32'({do_w[2], pe_w[2], fe_w[2]}), 32'({8'hFE, 2'b00}));
    send_frame(2, 8'h5A, model_par(8'h5A, 1), 1'b1, 1'b0, CPB);
    chk("t5_stop2_low", 32'(fe_w[2]), 32'd1);

    rx_line[0] = 1'b0;
    repeat (CPB) @(negedge clk);
    rx_line[0] = 1'b1;
    repeat (CPB) @(negedge clk);
    rx_line[0] = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    chk("t6_busy_mid_frame", 32'(busy_w[0]), 32'd1);
    @(posedge clk); #2 rst_n = 1'b0;
    rx_line[0] = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_after_reset", 32'({dv_w[0], do_w[0], busy_w[0]}), 32'd0);
    repeat (CPB) @(negedge clk);
    send_frame(0, 8'h42, 1'b0, 1'b1, 1'b1, CPB);
    chk("t6_next_word", 32'({do_w[0], fe_w[0]}), 32'({8'h42, 1'b0}));

    for (int r = 0; r < 30; r++) begin
      ri    = int'($urandom_range(0, N - 1));
      rd    = 8'($urandom);
      rp    = model_par(rd, p_odd[ri]) ^ ($urandom_range(0, 3) == 0);
      rs0   = ($urandom_range(0, 4) != 0);
      rs1   = ($urandom_range(0, 4) != 0);
      clean = rs0 && (s_bits[ri] == 1 || rs1);
      send_frame(ri, rd, rp, rs0, rs1,
                 clean ? int'($urandom_range(0, CPB)) : CPB + int'($urandom_range(0, CPB)));
    end

    repeat (3 * CPB) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
